sdram_frame_reader: RTL

- Read-side counterpart of the VideoController write path.
- Streams a stored frame out of SDRAM in fixed bursts and unpacks each 32-bit word into two 16-bit pixels.
- Pushes pixels into the display store FIFO as 17-bit items; bit16 marks frame start, matching the 17'h10000 command format of the camera load path.
- Sits between the SDRAM controller port and the LCD-side FIFO, in the memory clock domain.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/burst_unpacker.sv | 51 +++++
 rtl/sdram_frame_reader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the SDRAM frame read path.
package fb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    ISSUE,
    COLLECT,
    MARKER,
    DRAIN
  } fb_state_e;

  localparam logic        CMD_READ         = 1'b0;
  localparam logic        CMD_WRITE        = 1'b1;
  localparam logic [16:0] FRAME_START_ITEM = 17'h10000;

  // 32-bit words per memory burst
  function automatic int burst_words(input int memory_burst);
    return memory_burst / 4;
  endfunction

endpackage

// File: rtl/burst_unpacker.sv
// Captures one read burst and replays it as 16-bit pixels, low half first.
module burst_unpacker #(
  parameter int BURST_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic        full,
  output logic        collect_done,
  output logic        drain_done,
  output logic [15:0] pixel
);

  localparam int IW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int PW = $clog2(2 * BURST_WORDS);

  logic [31:0]   mem_q [BURST_WORDS];
  logic [IW-1:0] idx_q;
  logic [PW-1:0] ptr_q;
  logic [IW-1:0] wsel;
  logic          pop;

  assign pop          = rd_en && !full;
  assign collect_done = wr_en && (idx_q == IW'(BURST_WORDS - 1));
  assign drain_done   = pop && (ptr_q == PW'(2 * BURST_WORDS - 1));
  assign wsel         = IW'(ptr_q >> 1);
  assign pixel        = ptr_q[0] ? mem_q[wsel][31:16] : mem_q[wsel][15:0];

  // Burst storage; contents only matter once the index has filled it
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx_q] <= wr_data;
  end

  // Write index and pixel pointer; a new command discards any partial burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      ptr_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      if (wr_en) idx_q <= collect_done ? '0 : idx_q + 1'b1;
      if (pop)   ptr_q <= drain_done ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Reads a frame from SDRAM in bursts and feeds pixels to the display store FIFO.
module sdram_frame_reader
  import fb_pkg::*;
#(
  parameter int          MEMORY_BURST = 32,
  parameter logic [20:0] BASE_ADDR    = 21'h000000,
  parameter int          FRAME_WORDS  = 65280,
  parameter int          CMD_GAP      = 13,
  parameter int          DATA_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  output logic        cmd,
  output logic        cmd_en,
  output logic [20:0] addr,
  output logic [3:0]  data_mask,
  input  logic [31:0] rd_data,
  input  logic        rd_data_valid,
  output logic        store_clk_o,
  output logic        store_wr_en,
  output logic [16:0] store_queue_data,
  input  logic        store_queue_full,
  input  logic        store_queue_space,
  output logic        error
);

  localparam int BW = burst_words(MEMORY_BURST);
  localparam int TW = $clog2(DATA_TIMEOUT + 1);
  localparam int GW = $clog2(CMD_GAP + 1);

  fb_state_e     state_q, state_d;
  logic [20:0]   addr_q, wcnt_q;
  logic          pending_q, error_q;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] tmo_q;
  logic          timeout, collect_done, drain_done;
  logic [15:0]   pixel;

  assign timeout     = tmo_q >= TW'(DATA_TIMEOUT);
  assign cmd         = CMD_READ;
  assign data_mask   = 4'b0000;
  assign addr        = addr_q;
  assign error       = error_q;
  assign store_clk_o = clk;

  burst_unpacker #(.BURST_WORDS(BW)) u_unpack (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (state_q == ISSUE),
    .wr_en        (rd_data_valid && state_q == COLLECT),
    .wr_data      (rd_data),
    .rd_en        (state_q == DRAIN),
    .full         (store_queue_full),
    .collect_done (collect_done),
    .drain_done   (drain_done),
    .pixel        (pixel)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and Moore-style command/store outputs
  always_comb begin
    state_d          = state_q;
    cmd_en           = 1'b0;
    store_wr_en      = 1'b0;
    store_queue_data = '0;
    unique case (state_q)
      IDLE:       if (init_done && gap_q >= GW'(CMD_GAP)) state_d = WAIT_SPACE;
      WAIT_SPACE: if (store_queue_space) state_d = ISSUE;
      ISSUE: begin
        cmd_en  = 1'b1;
        state_d = COLLECT;
      end
      COLLECT: begin
        // a burst completing on the timeout cycle is still accepted
        if (collect_done) state_d = pending_q ? MARKER : DRAIN;
        else if (timeout) state_d = IDLE;
      end
      MARKER: begin
        store_wr_en      = !store_queue_full;
        store_queue_data = FRAME_START_ITEM;
        if (!store_queue_full) state_d = DRAIN;
      end
      DRAIN: begin
        store_wr_en      = !store_queue_full;
        store_queue_data = {1'b0, pixel};
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gap/timeout counters, frame position and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= BASE_ADDR;
      wcnt_q    <= '0;
      pending_q <= 1'b1;
      error_q   <= 1'b0;
      gap_q     <= '0;
      tmo_q     <= '0;
    end else begin
      if (state_q == ISSUE)           gap_q <= '0;
      else if (gap_q < GW'(CMD_GAP))  gap_q <= gap_q + 1'b1;

      if (state_q == ISSUE)                    tmo_q <= '0;
      else if (state_q == COLLECT && !timeout) tmo_q <= tmo_q + 1'b1;

      if (state_q == COLLECT && timeout && !collect_done) error_q <= 1'b1;

      if (state_q == MARKER && !store_queue_full) pending_q <= 1'b0;

      if (drain_done) begin
        if (wcnt_q + 21'(BW) == 21'(FRAME_WORDS)) begin
          addr_q    <= BASE_ADDR;
          wcnt_q    <= '0;
          pending_q <= 1'b1;
        end else begin
          addr_q <= addr_q + 21'(BW);
          wcnt_q <= wcnt_q + 21'(BW);
        end
      end
    end
  end

endmodule
